// File: rtl/data_bus_responder.sv
// Data RAM plus a 256-byte memory-mapped I/O page (GPIO, compare timer, write-fault capture).
// The compare timer (COUNT/CMP/CTRL, o_TimerIrq) exists only when DMEM_TIMER_EN is defined.
module data_bus_responder #(
    parameter int                         DATA_DBUS_WIDTH = 32,
    parameter int                         ADDR_DBUS_WIDTH = 32,
    parameter int                         RAM_WORDS_LOG2  = 10,
    parameter logic [ADDR_DBUS_WIDTH-1:0] IO_BASE         = 32'hFFFF_0000
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic [ADDR_DBUS_WIDTH-1:0] i_MemAddr,
    input  logic                       i_MemWrEnable,
    input  logic [DATA_DBUS_WIDTH-1:0] i_MemWrData,
    output logic [DATA_DBUS_WIDTH-1:0] o_MemRdData,
    output logic [DATA_DBUS_WIDTH-1:0] o_Gpio,
    output logic                       o_TimerIrq,
    output logic                       o_AddrFault
);

    localparam int RAM_DEPTH = 1 << RAM_WORDS_LOG2;

    // I/O register word offsets (byte offset / 4)
    localparam logic [5:0] OFF_GPIO  = 6'h00;
    localparam logic [5:0] OFF_COUNT = 6'h01;
    localparam logic [5:0] OFF_CMP   = 6'h02;
    localparam logic [5:0] OFF_CTRL  = 6'h03;
    localparam logic [5:0] OFF_FAULT = 6'h04;

    logic                       is_ram;
    logic                       is_io;
    logic                       aligned;
    logic                       wr_accept;
    logic                       wr_fault;
    logic                       wr_ram;
    logic                       wr_io;
    logic [RAM_WORDS_LOG2-1:0]  ram_index;
    logic [5:0]                 io_word;

    logic [DATA_DBUS_WIDTH-1:0] ram [RAM_DEPTH];
    logic [DATA_DBUS_WIDTH-1:0] gpio_q;
    logic [ADDR_DBUS_WIDTH-1:0] fault_addr_q;
    logic                       fault_pulse_q;

    assign is_ram    = (i_MemAddr[ADDR_DBUS_WIDTH-1:RAM_WORDS_LOG2+2] == '0);
    assign is_io     = (i_MemAddr[ADDR_DBUS_WIDTH-1:8] == IO_BASE[ADDR_DBUS_WIDTH-1:8]);
    assign aligned   = (i_MemAddr[1:0] == 2'b00);
    assign ram_index = i_MemAddr[RAM_WORDS_LOG2+1:2];
    assign io_word   = i_MemAddr[7:2];

    // Faults are raised only for writes; reserved and read-only I/O offsets are silently ignored.
    assign wr_accept = i_MemWrEnable & aligned & (is_ram | is_io);
    assign wr_fault  = i_MemWrEnable & ~(aligned & (is_ram | is_io));
    assign wr_ram    = wr_accept & is_ram;
    assign wr_io     = wr_accept & is_io & ~is_ram;

    always_ff @(posedge i_Clock) begin
        if (i_Reset && wr_ram) begin
            ram[ram_index] <= i_MemWrData;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            gpio_q        <= '0;
            fault_addr_q  <= '0;
            fault_pulse_q <= 1'b0;
        end else begin
            fault_pulse_q <= wr_fault;
            if (wr_fault) begin
                fault_addr_q <= i_MemAddr;
            end
            if (wr_io && io_word == OFF_GPIO) begin
                gpio_q <= i_MemWrData;
            end
        end
    end

`ifdef DMEM_TIMER_EN
    logic [DATA_DBUS_WIDTH-1:0] count_q;
    logic [DATA_DBUS_WIDTH-1:0] cmp_q;
    logic                       en_q;
    logic                       reload_q;
    logic                       flag_q;
    logic                       irqen_q;
    logic                       match;
    logic                       wr_ctrl;

    assign match   = en_q & (count_q == cmp_q);
    assign wr_ctrl = wr_io & (io_word == OFF_CTRL);

    // A CPU write to COUNT beats both increment and reload; a FLAG set beats a W1C clear.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            count_q  <= '0;
            cmp_q    <= '1;
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            flag_q   <= 1'b0;
            irqen_q  <= 1'b0;
        end else begin
            if (wr_io && io_word == OFF_COUNT) begin
                count_q <= i_MemWrData;
            end else if (en_q) begin
                count_q <= (match && reload_q) ? '0 : count_q + DATA_DBUS_WIDTH'(1);
            end
            if (wr_io && io_word == OFF_CMP) begin
                cmp_q <= i_MemWrData;
            end
            if (wr_ctrl) begin
                en_q     <= i_MemWrData[0];
                reload_q <= i_MemWrData[1];
                irqen_q  <= i_MemWrData[3];
            end
            if (match) begin
                flag_q <= 1'b1;
            end else if (wr_ctrl && i_MemWrData[2]) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign o_TimerIrq = flag_q & irqen_q;
`else
    assign o_TimerIrq = 1'b0;
`endif

    always_comb begin
        o_MemRdData = '0;
        if (is_ram) begin
            o_MemRdData = ram[ram_index];
        end else if (is_io) begin
            case (io_word)
                OFF_GPIO:  o_MemRdData = gpio_q;
`ifdef DMEM_TIMER_EN
                OFF_COUNT: o_MemRdData = count_q;
                OFF_CMP:   o_MemRdData = cmp_q;
                OFF_CTRL:  o_MemRdData = {{(DATA_DBUS_WIDTH-4){1'b0}}, irqen_q, flag_q, reload_q, en_q};
`endif
                OFF_FAULT: o_MemRdData = fault_addr_q;
                default:   o_MemRdData = '0;
            endcase
        end
    end

    assign o_Gpio      = gpio_q;
    assign o_AddrFault = fault_pulse_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: a reference model predicts every cycle's outputs,
// a monitor on the falling edge pops and compares them. Follows DMEM_TIMER_EN like the design.
module tb_data_bus_responder;

    localparam logic [31:0] IO = 32'hFFFF_0000;
`ifdef DMEM_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic [31:0] gpio;
    logic        irq;
    logic        fault;

    always #5 clk = ~clk;

    data_bus_responder dut (
        .i_Clock       (clk),
        .i_Reset       (rst_n),
        .i_MemAddr     (addr),
        .i_MemWrEnable (we),
        .i_MemWrData   (wdata),
        .o_MemRdData   (rd_data),
        .o_Gpio        (gpio),
        .o_TimerIrq    (irq),
        .o_AddrFault   (fault)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        rd_chk;
        logic [31:0] gpio;
        logic        irq;
        logic        fault;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_no = 0;

    // Reference model state
    logic [31:0] m_ram [1024];
    bit          m_known [1024];
    logic [31:0] m_gpio, m_count, m_cmp, m_fault_addr;
    bit          m_en, m_reload, m_flag, m_irqen, m_fault;

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a[31:12] == 20'h0) begin
            known = m_known[a[11:2]];
            return m_ram[a[11:2]];
        end
        if (a[31:8] != IO[31:8]) return 32'h0;
        case ({a[7:2], 2'b00})
            8'h00: return m_gpio;
            8'h04: return TIMER_ON ? m_count : 32'h0;
            8'h08: return TIMER_ON ? m_cmp : 32'h0;
            8'h0C: return TIMER_ON ? {28'h0, m_irqen, m_flag, m_reload, m_en} : 32'h0;
            8'h10: return m_fault_addr;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_gpio = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_fault_addr = 0;
        m_en = 0; m_reload = 0; m_flag = 0; m_irqen = 0; m_fault = 0;
    endtask

    task automatic m_step(input logic [31:0] a, input bit w, input logic [31:0] d, input bit r);
        bit is_ram, mapped, ok, hit;
        if (!r) begin
            m_reset();
            return;
        end
        is_ram = (a[31:12] == 20'h0);
        mapped = is_ram || (a[31:8] == IO[31:8]);
        ok     = w && mapped && (a[1:0] == 2'b00);
        hit    = TIMER_ON && m_en && (m_count == m_cmp);
        if (TIMER_ON && m_en) m_count = (hit && m_reload) ? 32'h0 : m_count + 32'd1;
        if (ok && is_ram) begin
            m_ram[a[11:2]]   = d;
            m_known[a[11:2]] = 1'b1;
        end else if (ok) begin
            case ({a[7:2], 2'b00})
                8'h00: m_gpio = d;
                8'h04: if (TIMER_ON) m_count = d;
                8'h08: if (TIMER_ON) m_cmp = d;
                8'h0C: if (TIMER_ON) begin
                    m_en = d[0]; m_reload = d[1]; m_irqen = d[3];
                    if (d[2]) m_flag = 1'b0;
                end
                default: ;
            endcase
        end
        if (hit) m_flag = 1'b1;
        m_fault = w && !ok;
        if (m_fault) m_fault_addr = a;
    endtask

    // One bus cycle: drive, predict this cycle's outputs, advance the model across the edge.
    task automatic cyc(input logic [31:0] a, input bit w, input logic [31:0] d, input bit r = 1'b1);
        exp_t e;
        bit   known;
        addr = a; we = w; wdata = d; rst_n = r;
        e.rd     = m_read(a, known);
        e.rd_chk = known;
        e.gpio   = m_gpio;
        e.irq    = TIMER_ON & m_flag & m_irqen;
        e.fault  = m_fault;
        e.addr   = a;
        exp_q.push_back(e);
        m_step(a, w, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want, input logic [31:0] a);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d addr=%h got=%h want=%h", name, cyc_no, a, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc_no++;
                if (e.rd_chk) check("rd_data", rd_data, e.rd, e.addr);
                check("gpio", gpio, e.gpio, e.addr);
                check("irq", {31'h0, irq}, {31'h0, e.irq}, e.addr);
                check("addr_fault", {31'h0, fault}, {31'h0, e.fault}, e.addr);
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        logic [9:0]  w;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
                w = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(1016, 1023));
                a = {20'h0, w, 2'b00};
            end
            4, 5, 6: a = IO | 32'($urandom_range(0, 9) * 4);
            7:       a = IO | 32'($urandom_range(0, 63) * 4);
            default: begin
                case ($urandom_range(0, 3))
                    0: a = 32'h0000_1000;
                    1: a = 32'h8000_0000;
                    2: a = 32'hFFFE_FFFC;
                    default: a = $urandom;
                endcase
            end
        endcase
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [31:0] a, d;
        rst_n = 1'b0; addr = 32'h0; we = 1'b0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();

        // Reset state
        cyc(IO + 32'h10, 0, 0);
        cyc(IO + 32'h0C, 0, 0);
        cyc(IO + 32'h08, 0, 0);
        cyc(IO, 0, 0);

        // RAM write/read, low address bits ignored on reads
        cyc(32'h10, 1, 32'hDEAD_BEEF);
        cyc(32'h10, 0, 0);
        cyc(32'h13, 0, 0);

        // Fault capture: misaligned then unmapped
        cyc(32'h12, 1, 32'h1111_2222);
        cyc(32'h10, 0, 0);
        cyc(IO + 32'h10, 0, 0);
        cyc(32'h8000_0000, 1, 32'h3);
        cyc(IO + 32'h10, 0, 0);
        cyc(IO + 32'h10, 1, 32'h5);
        cyc(IO + 32'h40, 1, 32'h6);
        cyc(IO + 32'h10, 0, 0);

        // Timer with reload
        cyc(IO + 32'h08, 1, 5);
        cyc(IO + 32'h04, 1, 0);
        cyc(IO + 32'h0C, 1, 32'hB);
        repeat (14) cyc(IO + 32'h04, 0, 0);
        for (int k = 0; k < 20 && !(m_flag && m_count != m_cmp); k++) cyc(IO + 32'h04, 0, 0);
        cyc(IO + 32'h0C, 1, 32'hF);
        cyc(IO + 32'h0C, 0, 0);
        for (int k = 0; k < 20 && !(m_en && m_count == m_cmp); k++) cyc(IO + 32'h04, 0, 0);
        cyc(IO + 32'h0C, 1, 32'hF);
        cyc(IO + 32'h0C, 0, 0);

        // Timer without reload, then wrap
        cyc(IO + 32'h0C, 1, 32'h4);
        cyc(IO + 32'h08, 1, 2);
        cyc(IO + 32'h04, 1, 0);
        cyc(IO + 32'h0C, 1, 32'h1);
        repeat (6) cyc(IO + 32'h04, 0, 0);
        cyc(IO + 32'h04, 1, 32'hFFFF_FFFE);
        repeat (4) cyc(IO + 32'h04, 0, 0);
        cyc(IO + 32'h0C, 0, 0);

        // GPIO and reset with a coincident write
        cyc(IO, 1, 32'h55AA);
        cyc(IO, 0, 0);
        cyc(IO, 1, 32'h1234, 1'b0);
        cyc(IO + 32'h0C, 0, 0);
        cyc(IO + 32'h08, 0, 0);
        cyc(IO, 0, 0);

        // Timer registers written then read back (zero when compiled out)
        cyc(IO + 32'h0C, 1, 32'hF);
        cyc(IO + 32'h04, 1, 7);
        cyc(IO + 32'h0C, 0, 0);
        cyc(IO + 32'h04, 0, 0);
        cyc(IO + 32'h0C, 1, 32'h4);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            a = rand_addr();
            if (a[31:8] == IO[31:8] && (a[7:0] == 8'h04 || a[7:0] == 8'h08))
                d = 32'($urandom_range(0, 30));
            else
                d = $urandom;
            cyc(a, ($urandom_range(0, 2) == 0), d, ($urandom_range(0, 199) != 0));
        end

        we = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
